// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter in front of a single-port
// synchronous-read RAM, with round-robin contention and a bounded data-port lock.
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // instruction port
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic                  d_lock,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // RAM port
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            r_state;
  logic                  r_last_d;     // 1: data port was granted most recently
  logic [3:0]            r_lock_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_i_rvalid;
  logic                  r_d_rvalid;

  logic                  w_i_gnt;
  logic                  w_d_gnt;
  logic                  w_lock_exit;

  // Grants are gated by reset_n so nothing is accepted while reset is held.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (reset_n) begin
      if (r_state == ST_LOCKED) begin
        w_d_gnt = d_req;
      end else begin
        w_i_gnt = i_req && (!d_req || r_last_d);
        w_d_gnt = d_req && !w_i_gnt;
      end
    end
  end

  always_comb begin
    w_lock_exit = (r_lock_cnt == 4'd15) || !d_req || (w_d_gnt && !d_lock);
  end

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign ram_addr = w_i_gnt ? i_addr : (w_d_gnt ? d_addr : r_addr);
  assign ram_data = w_d_gnt ? d_wdata : '0;
  assign ram_we   = w_d_gnt && d_we;
  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_ARB;
      r_last_d   <= 1'b1;
      r_lock_cnt <= 4'd0;
      r_addr     <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_i_rvalid <= w_i_gnt;
      r_d_rvalid <= w_d_gnt && !d_we;
      if (w_i_gnt || w_d_gnt) begin
        r_addr <= ram_addr;
      end
      if (w_i_gnt) begin
        r_last_d <= 1'b0;
      end else if (w_d_gnt) begin
        r_last_d <= 1'b1;
      end

      if (r_state == ST_ARB) begin
        if (w_d_gnt && d_lock) begin
          r_state    <= ST_LOCKED;
          r_lock_cnt <= 4'd0;
        end
      end else begin
        r_lock_cnt <= r_lock_cnt + 4'd1;
        if (w_lock_exit) begin
          r_state <= ST_ARB;
        end
        // A timed-out lock hands the next contention to the instruction port.
        if (r_lock_cnt == 4'd15) begin
          r_last_d <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (who wins, lock window length, shadow memory).
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk;
  logic          reset_n;
  logic          i_req, d_req, d_we, d_lock;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, ram_we;
  logic [DW-1:0] i_rdata, d_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Single-port synchronous-read RAM.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          ig, dg, irv, drv, we;
    logic [AW-1:0] addr;
  } exp_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_locked;
  int            m_lock_cycles;
  bit            m_last_d;
  bit            m_pend_i, m_pend_d;
  logic [DW-1:0] m_pdata;
  logic [AW-1:0] m_last_addr;

  task automatic model_reset();
    m_locked = 0; m_lock_cycles = 0; m_last_d = 1;
    m_pend_i = 0; m_pend_d = 0; m_last_addr = '0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    if (m_locked) begin
      e.ig = 1'b0;
      e.dg = d_req;
    end else begin
      e.ig = i_req && (!d_req || m_last_d);
      e.dg = d_req && !e.ig;
    end
    e.we   = e.dg && d_we;
    e.addr = e.ig ? i_addr : (e.dg ? d_addr : m_last_addr);
    e.irv  = m_pend_i;
    e.drv  = m_pend_d;
    return e;
  endfunction

  // Commits one accepted cycle; called right after the rising edge.
  task automatic model_tick(input exp_t e);
    m_pend_i = e.ig;
    m_pend_d = e.dg && !d_we;
    m_pdata  = ref_mem[e.addr];
    if (e.we) ref_mem[e.addr] = d_wdata;
    if (e.ig) begin m_last_d = 0; m_last_addr = e.addr; end
    if (e.dg) begin m_last_d = 1; m_last_addr = e.addr; end
    if (m_locked) begin
      m_lock_cycles++;
      if (m_lock_cycles == 16) begin
        m_locked = 0;
        m_last_d = 1;
      end else if (!d_req || !d_lock) begin
        m_locked = 0;
      end
    end else if (e.dg && d_lock) begin
      m_locked = 1;
      m_lock_cycles = 0;
    end
  endtask

  task automatic clk_step(input exp_t e);
    @(posedge clk);
    model_tick(e);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_we = 0; d_lock = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0;
    i_req = 1; d_req = 1; d_we = 1; d_lock = 1;
    i_addr = 9'h055; d_addr = 9'h0AA; d_wdata = 32'hFFFF_FFFF;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #4;
      n_cmp++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr} !== {5'b0, 9'h000}) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: got gnt=%b%b rv=%b%b we=%b addr=%h, want all zero",
                 k, i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    reset_n = 1;
  endtask

  task automatic test_fill();
    exp_t e;
    for (int a = 0; a < (1 << AW); a++) begin
      d_req = 1; d_we = 1; d_lock = 0; d_addr = AW'(a); d_wdata = $urandom;
      #3; e = model_out();
      n_cmp++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr} !== e || ram_data !== d_wdata) begin
        n_bad++;
        $display("FAIL fill a=%0d: got %h data=%h, want %h data=%h",
                 a, {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr}, ram_data, e, d_wdata);
      end
      clk_step(e);
    end
    idle_inputs();
  endtask

  task automatic test_single_read();
    exp_t e;
    d_req = 1; d_we = 1; d_addr = 9'h010; d_wdata = 32'hDEAD_BEEF;
    #3; e = model_out(); clk_step(e);
    idle_inputs();
    i_req = 1; i_addr = 9'h010;
    #3; e = model_out();
    n_cmp++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || ram_addr !== 9'h010) begin
      n_bad++;
      $display("FAIL single_read_gnt: got i_gnt=%b d_gnt=%b addr=%h, want 1 0 010", i_gnt, d_gnt, ram_addr);
    end
    clk_step(e);
    i_req = 0;
    #3;
    n_cmp++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_read_data: got i_rvalid=%b i_rdata=%h d_rvalid=%b, want 1 deadbeef 0",
               i_rvalid, i_rdata, d_rvalid);
    end
    e = model_out(); clk_step(e);
  endtask

  task automatic test_contention();
    exp_t e;
    do_reset();
    i_req = 1; d_req = 1; d_we = 0; d_lock = 0; i_addr = 9'h003; d_addr = 9'h007;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin i_req = 0; d_req = 0; end
      #3; e = model_out();
      n_cmp++;
      if (i_gnt !== (k < 4 && k % 2 == 0) || d_gnt !== (k < 4 && k % 2 == 1) ||
          i_rvalid !== (k > 0 && (k - 1) % 2 == 0) || d_rvalid !== (k > 0 && (k - 1) % 2 == 1)) begin
        n_bad++;
        $display("FAIL contention cyc%0d: got gnt=%b%b rv=%b%b", k, i_gnt, d_gnt, i_rvalid, d_rvalid);
      end
      if (k > 0) begin
        n_cmp++;
        if (ram_q !== m_pdata) begin
          n_bad++;
          $display("FAIL contention_rdata cyc%0d: got %h, want %h", k, ram_q, m_pdata);
        end
      end
      clk_step(e);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    d_req = 1; d_we = 1; d_addr = 9'h1FF; d_wdata = 32'h1234_5678;
    #3; e = model_out(); clk_step(e);
    d_we = 0; d_wdata = '0;
    #3; e = model_out(); clk_step(e);
    d_req = 0;
    #3;
    n_cmp++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678 || i_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL write_read: got d_rvalid=%b d_rdata=%h i_rvalid=%b, want 1 12345678 0",
               d_rvalid, d_rdata, i_rvalid);
    end
    e = model_out(); clk_step(e);
  endtask

  task automatic test_lock_timeout();
    exp_t e;
    do_reset();
    i_req = 1; d_req = 1; d_we = 0; d_lock = 1; i_addr = 9'h020; d_addr = 9'h021;
    // cycle 0: instruction wins, 1: data takes the lock, 2..17: locked, 18: instruction again
    for (int k = 0; k < 19; k++) begin
      #3; e = model_out();
      n_cmp++;
      if (i_gnt !== (k == 0 || k == 18) || d_gnt !== !(k == 0 || k == 18) ||
          {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr} !== e) begin
        n_bad++;
        $display("FAIL lock_timeout cyc%0d: got %h, want %h", k,
                 {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr}, e);
      end
      clk_step(e);
    end
    idle_inputs();
  endtask

  task automatic test_lock_release();
    exp_t e;
    do_reset();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 9'h030; d_addr = 9'h031;
    for (int k = 0; k < 6; k++) begin
      d_lock = (k < 4);
      #3; e = model_out();
      n_cmp++;
      if (i_gnt !== (k == 0 || k == 5) || d_gnt !== (k >= 1 && k <= 4) ||
          {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr} !== e) begin
        n_bad++;
        $display("FAIL lock_release cyc%0d: got gnt=%b%b, want %b%b", k, i_gnt, d_gnt,
                 (k == 0 || k == 5), (k >= 1 && k <= 4));
      end
      clk_step(e);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    i_req = 1; i_addr = 9'h010;
    #3;
    n_cmp++;
    if (i_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_gnt: got i_gnt=%b, want 1", i_gnt);
    end
    @(posedge clk); #1;
    reset_n = 0;
    i_req = 0;
    model_reset();
    #3;
    n_cmp++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr} !== {5'b0, 9'h000}) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got gnt=%b%b rv=%b%b we=%b addr=%h, want all zero",
               i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr);
    end
    @(posedge clk); #1;
    reset_n = 1;
    #3;
    n_cmp++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_after: got rv=%b%b, want 00", i_rvalid, d_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_t e;
    bit ip = 0, dp = 0;
    idle_inputs();
    for (int k = 0; k < 400; k++) begin
      if (!ip && ($urandom % 3 != 0)) begin
        ip = 1; i_addr = AW'($urandom_range(0, 15));
      end
      if (!dp && ($urandom % 3 != 0)) begin
        dp = 1; d_we = $urandom % 2; d_lock = ($urandom % 4 == 0);
        d_addr = AW'($urandom_range(0, 15)); d_wdata = $urandom;
      end
      i_req = ip; d_req = dp;
      #3; e = model_out();
      n_cmp++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr} !== e) begin
        n_bad++;
        $display("FAIL random_ctl cyc%0d: got %h, want %h", k,
                 {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_we, ram_addr}, e);
      end
      if (e.irv || e.drv) begin
        n_cmp++;
        if ((e.irv && i_rdata !== m_pdata) || (e.drv && d_rdata !== m_pdata)) begin
          n_bad++;
          $display("FAIL random_rdata cyc%0d: got i=%h d=%h, want %h", k, i_rdata, d_rdata, m_pdata);
        end
      end
      if (e.we) begin
        n_cmp++;
        if (ram_data !== d_wdata) begin
          n_bad++;
          $display("FAIL random_wdata cyc%0d: got %h, want %h", k, ram_data, d_wdata);
        end
      end
      clk_step(e);
      if (e.ig) ip = 0;
      if (e.dg) dp = 0;
    end
    idle_inputs();
    #3; e = model_out(); clk_step(e);
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_fill();
    test_single_read();
    test_contention();
    test_write_read();
    test_lock_timeout();
    test_lock_release();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of both ports and the RAM bus.
REQ-002 Parameter ADDR_WIDTH, default 9, SHALL set the word-address width of both ports and the RAM bus.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_req input 1, i_addr input ADDR_WIDTH: instruction-port read request and address.
REQ-006 i_gnt output 1, i_rvalid output 1, i_rdata output DATA_WIDTH: instruction-port grant, read-data valid, read data.
REQ-007 d_req input 1, d_we input 1, d_lock input 1, d_addr input ADDR_WIDTH, d_wdata input DATA_WIDTH: data-port request, write enable, lock request, address, write data.
REQ-008 d_gnt output 1, d_rvalid output 1, d_rdata output DATA_WIDTH: data-port grant, read-data valid, read data.
REQ-009 ram_addr output ADDR_WIDTH, ram_data output DATA_WIDTH, ram_we output 1, ram_q input DATA_WIDTH: port to the single-port synchronous-read RAM (address registered on clk, q valid the following cycle).

Function
REQ-010 An access SHALL be accepted in the cycle where req and gnt are both high; at most one access per cycle is accepted.
REQ-011 Requesters SHALL hold req, addr, we, wdata stable until granted; the arbiter need not tolerate changes before grant.
REQ-012 gnt outputs SHALL be combinational from req and arbiter state; at most one of i_gnt, d_gnt is high in any cycle.
REQ-013 In the accept cycle, ram_addr/ram_data/ram_we SHALL be driven combinationally from the granted port; ram_we = d_we for the data port, 0 for the instruction port; when no grant, ram_we = 0 and ram_addr = last driven address.
REQ-014 For an accepted read in cycle N, the owning port's rvalid SHALL be high for exactly cycle N+1 with rdata = ram_q; accepted writes produce no rvalid.
REQ-015 i_rdata and d_rdata SHALL both carry ram_q; only rvalid qualifies them.
REQ-016 Back-to-back accepts SHALL be supported at full rate (one per cycle), responses in order.
REQ-017 FSM states: ARB, LOCKED.
REQ-018 ARB: only one req high -> grant it; both high -> grant the port not granted most recently (round-robin pointer last_gnt updated on every accept).
REQ-019 ARB -> LOCKED when a data-port access is accepted with d_lock = 1.
REQ-020 LOCKED: only d_gnt may be asserted (when d_req high); i_gnt = 0.
REQ-021 LOCKED -> ARB when a data access is accepted with d_lock = 0, when d_req is low in a LOCKED cycle, or when lock_cnt reaches 15.
REQ-022 lock_cnt (4 bits) SHALL clear on ARB -> LOCKED and increment each LOCKED cycle; on timeout exit, last_gnt is set to data so a pending i_req wins the next contention.
REQ-023 Write then read of the same address in consecutive cycles SHALL return the newly written data (RAM semantics; no forwarding logic).

Reset
REQ-024 While reset_n is low: i_gnt = d_gnt = 0, i_rvalid = d_rvalid = 0, ram_we = 0, ram_addr = 0, FSM = ARB, lock_cnt = 0, last_gnt = data (instruction port wins first contention).
REQ-025 Reset asserted mid-operation SHALL drop any pending response; no rvalid is produced for an access accepted in the cycle reset asserts.
REQ-026 First accept is possible in the first cycle after reset_n deasserts.

Verification
REQ-027 Single read: i_req=1, i_addr=0x010, RAM[0x010]=0xDEADBEEF -> i_gnt=1 in cycle N, i_rvalid=1 with i_rdata=0xDEADBEEF in N+1, d_rvalid=0.
REQ-028 Contention: i_req=d_req=1 held for 4 cycles after reset -> grants alternate I,D,I,D; rvalids follow one cycle later in the same order.
REQ-029 Write-then-read: d_we=1, d_addr=0x1FF, d_wdata=0x12345678, next cycle d_we=0 same address -> d_rvalid=1 with d_rdata=0x12345678 two cycles after the write.
REQ-030 Lock: d_lock=1 with i_req=1 held -> i_gnt=0 for 16 locked cycles, then timeout -> i_gnt=1 next contention cycle.
REQ-031 Lock release: d_lock=1 for 3 accesses then d_lock=0 access -> FSM returns to ARB; pending i_req granted the next cycle.
REQ-032 Reset mid-read: reset_n low in cycle after i_gnt -> i_rvalid stays 0, all outputs at REQ-024 values.
